serial_full_adder: RTL and testbench



---
 rtl/serial_full_adder_if.sv | 34 +++
 rtl/serial_full_adder.sv | 123 ++++++++++++
 tb/tb_serial_full_adder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/serial_full_adder_if.sv
// Operand/result handshake bundle for serial_full_adder.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_ready;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        input  in_ready, out_valid, sum, cout,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a, b, cin, out_ready
    );

    modport slave (
        output in_ready, out_valid, sum, cout,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin, out_ready
    );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial LSB-first adder: one full-adder cell and a carry FF iterated WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN adds a sub input selecting a - b (a + ~b + 1).
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    serial_full_adder_if.slave bus
);
    localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shifted;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             c_q;
    logic             cout_q;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_comb begin
        bit_s       = fa_sum(a_sh[0], b_sh[0], c_q);
        bit_c       = fa_carry(a_sh[0], b_sh[0], c_q);
        sum_shifted = sum_sh >> 1;
        sum_shifted[WIDTH-1] = bit_s;
    end

    // Subtraction reuses the adder: invert b on capture and force carry-in to 1.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_load = bus.sub ? ~bus.b : bus.b;
        c_load = bus.sub ? 1'b1 : bus.cin;
`else
        b_load = bus.b;
        c_load = bus.cin;
`endif
    end

    assign accept = (state == IDLE) && bus.start;
    assign last   = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            c_q    <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= b_load;
            c_q    <= c_load;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_shifted;
            c_q    <= bit_c;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum_q  <= sum_shifted;
                cout_q <= bit_c;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_full_adder.sv
// Directed-vector bench for serial_full_adder at WIDTH=8.
// Exercises handshakes, carries, back-pressure, ignored starts and mid-run reset.
module tb_serial_full_adder;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n;

    serial_full_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_full_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic handshake(input logic [7:0] exp_sum);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("post_hs_valid", bus.out_valid, 0);
        check_val("post_hs_in_ready", bus.in_ready, 1);
        check_val("post_hs_sum_kept", bus.sum, exp_sum);
    endtask

    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_cin,
                         input logic op_sub, input logic [7:0] exp_sum, input logic exp_cout,
                         input int hold);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_val("in_ready_wait", bus.in_ready, 1);
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.b     = op_b;
        bus.cin   = op_cin;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = op_sub;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~op_a;
        bus.b     = ~op_b;
        bus.cin   = ~op_cin;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = ~op_sub;
`endif
        check_val("busy_in_ready", bus.in_ready, 0);
        wait_valid(w);
        check_val("latency", w, WIDTH);
        check_val("sum", bus.sum, exp_sum);
        check_val("cout", bus.cout, exp_cout);
        for (int i = 0; i < hold; i++) begin
            bus.start = 1'b1;
            bus.a     = 8'h77;
            bus.b     = 8'h11;
            @(negedge clk);
            check_val("hold_valid", bus.out_valid, 1);
            check_val("hold_sum", bus.sum, exp_sum);
        end
        bus.start = 1'b0;
        handshake(exp_sum);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        #12;
        check_val("rst_in_ready", bus.in_ready, 1);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_sum", bus.sum, 0);
        check_val("rst_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0);
        do_op(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 0);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 10);

        // Second start during RUN must be ignored.
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("run_in_ready", bus.in_ready, 0);
        wait_valid(n);
        check_val("ignored_start_valid", bus.out_valid, 1);
        check_val("ignored_start_sum", bus.sum, 8'hFF);
        check_val("ignored_start_cout", bus.cout, 0);
        handshake(8'hFF);

        // Reset in the middle of RUN abandons the operation.
        bus.start = 1'b1;
        bus.a     = 8'hF0;
        bus.b     = 8'hF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", bus.out_valid, 0);
        check_val("midrst_sum", bus.sum, 0);
        check_val("midrst_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("postrst_in_ready", bus.in_ready, 1);
        repeat (10) @(negedge clk);
        check_val("postrst_no_valid", bus.out_valid, 0);
        do_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0);
        do_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 0);
        do_op(8'h20, 8'h05, 1'b1, 1'b0, 8'h26, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
